// File: rtl/dr32e_data_arb.sv
// Round-robin arbiter sharing the core data-memory port between the LSU (m0) and debug/DMA (m1).
// Zero-latency address forwarding, one outstanding transaction, response watchdog.
module dr32e_data_arb #(
    parameter int unsigned MemDataWidth  = 32,
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned TimeoutWidth  = $clog2(TimeoutCycles + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [3:0]              m0_be_i,
    input  logic [31:0]             m0_addr_i,
    input  logic [MemDataWidth-1:0] m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [MemDataWidth-1:0] m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [3:0]              m1_be_i,
    input  logic [31:0]             m1_addr_i,
    input  logic [MemDataWidth-1:0] m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [MemDataWidth-1:0] m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [31:0]             data_addr_o,
    output logic [MemDataWidth-1:0] data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [MemDataWidth-1:0] data_rdata_i,
    input  logic                    data_bus_err_i,
    input  logic                    data_pmp_err_i,

    output logic                    stray_rvalid_o,
    output logic                    timeout_o
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [TimeoutWidth-1:0] wdog_q, wdog_d;

    logic winner, sel, sel_req, bus_req, gnt_fire;
    logic rsp_fire, to_fire, resp_out, err;

    // Ties go to whichever master did not win last time.
    always_comb begin
        winner = 1'b0;
        if (m0_req_i && m1_req_i) begin
            winner = ~last_q;
        end else if (m1_req_i) begin
            winner = 1'b1;
        end
    end

    assign sel      = (state_q == IDLE) ? winner : owner_q;
    assign sel_req  = sel ? m1_req_i : m0_req_i;
    assign bus_req  = (state_q != RESP) && sel_req;
    assign gnt_fire = bus_req && data_gnt_i;

    assign rsp_fire = (state_q == RESP) && data_rvalid_i;
    assign to_fire  = (state_q == RESP) && !data_rvalid_i &&
                      (wdog_q == TimeoutWidth'(TimeoutCycles - 1));
    assign resp_out = rsp_fire || to_fire;
    assign err      = to_fire || (rsp_fire && (data_bus_err_i || data_pmp_err_i));

    assign data_req_o   = bus_req;
    assign data_we_o    = bus_req && (sel ? m1_we_i : m0_we_i);
    assign data_be_o    = bus_req ? (sel ? m1_be_i : m0_be_i) : 4'h0;
    assign data_addr_o  = bus_req ? (sel ? m1_addr_i : m0_addr_i) : 32'h0;
    assign data_wdata_o = bus_req ? (sel ? m1_wdata_i : m0_wdata_i) : '0;

    assign m0_gnt_o    = gnt_fire && !sel;
    assign m1_gnt_o    = gnt_fire && sel;
    assign m0_rvalid_o = resp_out && !owner_q;
    assign m1_rvalid_o = resp_out && owner_q;
    assign m0_err_o    = err && !owner_q;
    assign m1_err_o    = err && owner_q;
    assign m0_rdata_o  = to_fire ? '0 : data_rdata_i;
    assign m1_rdata_o  = to_fire ? '0 : data_rdata_i;

    // Anything arriving outside RESP (including late replies after a timeout) is dropped.
    assign stray_rvalid_o = data_rvalid_i && (state_q != RESP);
    assign timeout_o      = to_fire;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (bus_req) begin
                    owner_d = winner;
                    if (data_gnt_i) begin
                        last_d  = winner;
                        state_d = RESP;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (gnt_fire) begin
                    last_d  = owner_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                wdog_d = wdog_q + TimeoutWidth'(1);
                if (resp_out) begin
                    wdog_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: doc/dr32e_data_arb.md
Name: dr32e_data_arb

Overview:
- Two-requester arbiter for the single core data-memory port.
- Shares the port between the LSU (master 0) and a debug/DMA requester (master 1).
- Sits between the LSU and the data bus: forwards address phase, routes grant and response back to the owner, and keeps one transaction outstanding.
- Includes a response watchdog so a lost rvalid cannot hang the core.

Parameters:
- MemDataWidth, 32: data width of rdata/wdata on all ports.
- TimeoutCycles, 64: response-phase cycles before the watchdog fires; minimum 2.
- TimeoutWidth, $clog2(TimeoutCycles+1): watchdog counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mN_req_i  in  1  request, held until granted (N=0 LSU, N=1 debug/DMA; every mN_ port exists per master)
- mN_we_i  in  1  write enable
- mN_be_i  in  4  byte enables
- mN_addr_i  in  32  address
- mN_wdata_i  in  MemDataWidth  write data
- mN_gnt_o  out  1  address phase accepted
- mN_rvalid_o  out  1  response valid
- mN_rdata_o  out  MemDataWidth  read data
- mN_err_o  out  1  bus_err | pmp_err | timeout
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write enable
- data_be_o  out  4  bus byte enables
- data_addr_o  out  32  bus address
- data_wdata_o  out  MemDataWidth  bus write data
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_rdata_i  in  MemDataWidth  bus read data
- data_bus_err_i  in  1  bus error, valid with rvalid
- data_pmp_err_i  in  1  PMP error, valid with rvalid
- stray_rvalid_o  out  1  pulse: rvalid received with no transaction outstanding
- timeout_o  out  1  pulse: watchdog fired

Behaviour:
- State machine: IDLE, ADDR (address phase pending, owner locked), RESP (awaiting rvalid). Registers: owner (1b), last_winner (1b), wdog counter.
- Reset: state=IDLE, last_winner=1 so master 0 wins the first tie, wdog=0.
  - All outputs 0 at and after reset until a request arrives.
  - rdata outputs are the only exception: they may pass through data_rdata_i unconditionally.
- Arbitration (IDLE only, combinational):
  - If only one master requests, it wins.
  - If both request, the master that is not last_winner wins (round-robin).
  - Winner's signals are muxed onto data_*_o and data_req_o=1 in the same cycle (zero added latency).
- IDLE, data_gnt_i=1: winner's mN_gnt_o=1 the same cycle; owner←winner; last_winner←winner; →RESP.
- IDLE, request present, no gnt: owner←winner; →ADDR.
- ADDR:
  - Only the owner's signals are driven onto the bus; the other master cannot preempt.
  - On data_gnt_i: owner gnt_o=1, last_winner←owner, →RESP.
  - A master must not drop req before gnt. If owner req drops anyway, data_req_o follows it low and state stays ADDR.
- RESP:
  - data_req_o=0; no new address phase is issued (single outstanding transaction).
  - wdog increments every cycle.
  - On data_rvalid_i: owner rvalid_o=1, rdata=data_rdata_i, err_o=bus_err|pmp_err, wdog←0, →IDLE. New arbitration starts the next cycle.
- Watchdog:
  - In RESP with wdog==TimeoutCycles-1 and no rvalid: owner rvalid_o=1, err_o=1, rdata=0, timeout_o=1, wdog←0, →IDLE.
  - rvalid arriving in the same cycle as the timeout takes priority: normal response, no timeout_o.
- Stray response: data_rvalid_i while in IDLE or ADDR is dropped (no mN_rvalid_o) and stray_rvalid_o=1 for one cycle. This covers a late response after a timeout.
- Grant and rvalid outputs go only to the owner/winner; the non-owner always sees gnt=0 and rvalid=0.
- Reset in any state: synchronous return to IDLE next edge; any in-flight response is then treated as stray.

Test Plan:
- Single LSU read: m0 req addr=0x100, gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> m0_gnt_o in cycle 0, m0_rvalid_o with 0xDEADBEEF, err=0; m1 outputs stay 0.
- Contention: m0 and m1 both request from reset for 4 back-to-back transactions, gnt immediate, rvalid +1 cycle -> grant order m0,m1,m0,m1; bus addresses match the winners.
- Grant stall lock: m0 requests, gnt withheld 3 cycles, m1 requests in cycle 1 -> data_addr_o stays m0's address until gnt; m1 is granted only after m0's rvalid.
- Error routing: m1 write with data_pmp_err_i=1 on rvalid -> m1_rvalid_o=1, m1_err_o=1; m0 untouched.
- Timeout: TimeoutCycles=4, m0 read granted, no rvalid -> m0_rvalid_o=1, m0_err_o=1, timeout_o=1 on the 4th RESP cycle. A later rvalid -> stray_rvalid_o=1 and no mN_rvalid_o.
- Reset mid-RESP: assert rst_i one cycle while in RESP -> state IDLE, all outputs 0; a subsequent rvalid -> stray_rvalid_o=1.
